scs8hd_o21a_bist_ctl: RTL and testbench
=======================================

SCS8HD_O21A_BIST_CTL -- requirements
Module: scs8hd_o21a_bist_ctl

Interface
REQ-001 The block SHALL expose parameter SETTLE_CYCLES, default 2, meaning the number of cycles each vector is held before sampling; legal range 1..15.
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port START, input, 1 bit: run request, sampled only in IDLE.
REQ-005 The block SHALL have port ABORT, input, 1 bit: cancels an active run.
REQ-006 The block SHALL have port X_OBS, input, 1 bit: observed X output of the o21a cell under test.
REQ-007 The block SHALL have ports A1, A2 and B1, each output, 1 bit: stimulus driven to the cell under test.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high while a run is active.
REQ-009 The block SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of a completed run.
REQ-010 The block SHALL have port PASS, output, 1 bit: result of the last completed run; sticky.
REQ-011 The block SHALL have port ERR_CNT, output, 4 bits: number of mismatching vectors in the current or last run.
REQ-012 The block SHALL have port FAIL_VEC, output, 3 bits: index of the first mismatching vector.
REQ-013 The block SHALL have no power/ground pins; it is digital control logic, not a library cell.

Function
REQ-014 The block SHALL implement the states IDLE, SETTLE, SAMPLE and FINISH.
REQ-015 In IDLE with START=1, the block SHALL clear the vector index, ERR_CNT, FAIL_VEC and PASS, load the settle counter with SETTLE_CYCLES, and enter SETTLE on the next edge.
REQ-016 The stimulus SHALL be {A1,A2,B1} = index[2:0]; vectors are applied in order 0..7 with no skips.
REQ-017 In IDLE and FINISH, the block SHALL drive A1, A2 and B1 to 0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with the vector held stable, and then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle, with the same vector driven.
REQ-020 In SAMPLE, the block SHALL compare X_OBS against expected = (A1|A2)&B1.
REQ-021 On a mismatch in SAMPLE, ERR_CNT SHALL increment by 1; the maximum count is 8, so no saturation is needed.
REQ-022 On the first mismatch of a run (ERR_CNT==0 before the increment), FAIL_VEC SHALL capture the vector index; later mismatches SHALL leave it unchanged.
REQ-023 From SAMPLE with index<7, the block SHALL increment the index, reload the settle counter and return to SETTLE.
REQ-024 From SAMPLE with index==7, the block SHALL go to FINISH; the index SHALL NOT wrap within a run.
REQ-025 In FINISH, the block SHALL assert DONE for exactly one cycle, set PASS = (final ERR_CNT==0) including any mismatch found at vector 7, and return to IDLE on the next edge.
REQ-026 Latency: DONE SHALL be high on cycle 8*(SETTLE_CYCLES+1)+1, counted from the edge that sampled START.
REQ-027 BUSY SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and FINISH.
REQ-028 START SHALL be ignored outside IDLE.
REQ-029 A START held high continuously SHALL begin a new run on the edge after FINISH.
REQ-030 ABORT=1 in SETTLE or SAMPLE SHALL return the block to IDLE on the next edge, with no DONE, PASS=0, and ERR_CNT/FAIL_VEC holding their partial values.
REQ-031 ABORT SHALL take priority over the SAMPLE compare in the same cycle, so that compare is discarded.
REQ-032 ABORT in IDLE or FINISH SHALL have no effect.
REQ-033 ERR_CNT, FAIL_VEC and PASS SHALL hold their values in IDLE until the next accepted START.
REQ-034 X_OBS SHALL be used only on the SAMPLE-cycle edge; all outputs SHALL be registered.

Reset
REQ-035 With RESET=1 at a rising edge, the block SHALL enter IDLE and force A1=A2=B1=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, index=0 and the settle counter to 0.
REQ-036 RESET SHALL override START and ABORT.
REQ-037 RESET asserted mid-run SHALL discard the run without asserting DONE.

Verification
REQ-038 The bench SHALL check reset: RESET high for 2 cycles, then low -> all outputs 0, state IDLE, and no activity until START.
REQ-039 The bench SHALL check a good cell: SETTLE_CYCLES=2, X_OBS=(A1|A2)&B1, 1-cycle START -> vectors 0..7 each held 3 cycles, DONE on cycle 25 only, PASS=1, ERR_CNT=0, FAIL_VEC=0.
REQ-040 The bench SHALL check stuck-at-0: X_OBS=0 -> mismatches at vectors 3, 5 and 7, ERR_CNT=3, FAIL_VEC=3, PASS=0, DONE on cycle 25.
REQ-041 The bench SHALL check stuck-at-1: X_OBS=1 -> mismatches at vectors 0, 1, 2, 4 and 6, ERR_CNT=5, FAIL_VEC=0, PASS=0.
REQ-042 The bench SHALL check ABORT: ABORT for 1 cycle while vector 4 is in SETTLE -> IDLE on the next edge, stimulus 0, no DONE, PASS=0; a second START restarts from vector 0 and completes normally.
REQ-043 The bench SHALL check ignored START and mid-run reset: START pulses during BUSY -> no restart and DONE still on cycle 25; RESET mid-SAMPLE -> all outputs 0 on the next edge and no DONE.

Source files
------------

// File: rtl/scs8hd_o21a_bist_ctl_if.sv
// scs8hd_o21a_bist_ctl_if: run control, cell stimulus/observe and result signals of the o21a BIST controller
interface scs8hd_o21a_bist_ctl_if;
    logic       START;
    logic       ABORT;
    logic       X_OBS;
    logic       A1;
    logic       A2;
    logic       B1;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [3:0] ERR_CNT;
    logic [2:0] FAIL_VEC;
    modport master (
        output START, ABORT, X_OBS,
        input  A1, A2, B1, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
    );
    modport slave (
        input  START, ABORT, X_OBS,
        output A1, A2, B1, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
    );
endinterface

// File: rtl/scs8hd_o21a_bist_ctl.sv
// scs8hd_o21a_bist_ctl: walks the 8 input vectors of an o21a cell, compares X against (A1|A2)&B1, reports pass/fail
module scs8hd_o21a_bist_ctl #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic                   CLK,
    input logic                   RESET,
    scs8hd_o21a_bist_ctl_if.slave bus
);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
    state_t     state, state_n;
    logic [2:0] idx, idx_n, stim_n;
    logic [3:0] cnt, err_n;
    logic       start_ok, hit, busy_n, done_n;
    assign start_ok = state == IDLE && bus.START;
    // ABORT discards the compare of the cycle it arrives in
    assign hit   = state == SAMPLE && !bus.ABORT && bus.X_OBS != ((idx[2] | idx[1]) & idx[0]);
    assign err_n = bus.ERR_CNT + {3'd0, hit};
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            idx          <= 3'd0;
            cnt          <= 4'd0;
            bus.BUSY     <= 1'b0;
            bus.DONE     <= 1'b0;
            bus.PASS     <= 1'b0;
            bus.ERR_CNT  <= 4'd0;
            bus.FAIL_VEC <= 3'd0;
            {bus.A1, bus.A2, bus.B1} <= 3'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            bus.BUSY <= busy_n;
            bus.DONE <= done_n;
            {bus.A1, bus.A2, bus.B1} <= stim_n;
            if (start_ok || (state == SAMPLE && state_n == SETTLE))
                cnt <= SETTLE_LD;
            else if (state == SETTLE)
                cnt <= cnt - 4'd1;
            if (start_ok) begin
                bus.ERR_CNT  <= 4'd0;
                bus.FAIL_VEC <= 3'd0;
                bus.PASS     <= 1'b0;
            end else begin
                bus.ERR_CNT <= err_n;
                if (hit && bus.ERR_CNT == 4'd0)
                    bus.FAIL_VEC <= idx;
                if (state_n == FINISH)
                    bus.PASS <= err_n == 4'd0;
            end
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                state_n = bus.START ? SETTLE : IDLE;
                idx_n   = 3'd0;
            end
            SETTLE: state_n = bus.ABORT ? IDLE : (cnt == 4'd1) ? SAMPLE : SETTLE;
            SAMPLE: begin
                state_n = bus.ABORT ? IDLE : (idx == 3'd7) ? FINISH : SETTLE;
                idx_n   = (state_n == SETTLE) ? idx + 3'd1 : idx;
            end
            default: state_n = IDLE;
        endcase
    end
    // outputs are registered from the next-state view so they line up with the state
    always_comb begin
        busy_n = state_n == SETTLE || state_n == SAMPLE;
        done_n = state_n == FINISH;
        stim_n = busy_n ? idx_n : 3'd0;
    end
endmodule

// File: tb/tb_scs8hd_o21a_bist_ctl.sv
// tb_scs8hd_o21a_bist_ctl: directed runs against good, stuck-at-0 and stuck-at-1 cell models
module tb_scs8hd_o21a_bist_ctl;
    logic CLK = 1'b0;
    logic RESET;
    int   mode;
    int   n_cmp = 0;
    int   n_bad = 0;
    scs8hd_o21a_bist_ctl_if bus ();
    scs8hd_o21a_bist_ctl #(.SETTLE_CYCLES(2)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;
    // cell under test: 0 good, 1 stuck-at-0, 2 stuck-at-1
    assign bus.X_OBS = (mode == 0) ? ((bus.A1 | bus.A2) & bus.B1) : (mode == 2);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_idle(input string tag, input logic [3:0] e_err, input logic [2:0] e_fail, input logic e_pass);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_stim"}, 32'({bus.A1, bus.A2, bus.B1}), 32'd0);
        chk({tag, "_done"}, 32'(bus.DONE), 32'd0);
        chk({tag, "_err"}, 32'(bus.ERR_CNT), 32'(e_err));
        chk({tag, "_fail"}, 32'(bus.FAIL_VEC), 32'(e_fail));
        chk({tag, "_pass"}, 32'(bus.PASS), 32'(e_pass));
    endtask
    task automatic run(input string tag, input int m, input bit poke,
                       input logic [3:0] e_err, input logic [2:0] e_fail, input logic e_pass);
        int n_done = 0;
        int done_at = 0;
        int bad_seq = 0;
        logic pass_at_done = 1'b0;
        logic [2:0] e_vec;
        mode = m;
        @(negedge CLK);
        bus.START = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge CLK);
            bus.START = poke && (k == 5 || k == 14);
            e_vec = (k <= 24) ? 3'((k - 1) / 3) : 3'd0;
            if ({bus.A1, bus.A2, bus.B1} !== e_vec || bus.BUSY !== (k <= 24)) bad_seq++;
            if (bus.DONE === 1'b1) begin
                n_done++;
                done_at = k;
                pass_at_done = bus.PASS;
            end
        end
        chk({tag, "_seq"}, 32'(bad_seq), 32'd0);
        chk({tag, "_ndone"}, 32'(n_done), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_at), 32'd25);
        chk({tag, "_pass_at_done"}, 32'(pass_at_done), 32'(e_pass));
        chk_idle(tag, e_err, e_fail, e_pass);
    endtask
    initial begin
        int n_done;
        mode = 0;
        RESET = 1'b1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk_idle("reset", 4'd0, 3'd0, 1'b0);
        n_done = 0;
        repeat (5) begin
            @(negedge CLK);
            if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) n_done++;
        end
        chk("reset_quiet", 32'(n_done), 32'd0);
        run("good", 0, 1'b0, 4'd0, 3'd0, 1'b1);
        repeat (3) @(negedge CLK);
        chk("good_sticky_pass", 32'(bus.PASS), 32'd1);
        run("sa0", 1, 1'b0, 4'd3, 3'd3, 1'b0);
        run("sa1", 2, 1'b0, 4'd5, 3'd0, 1'b0);
        run("poke", 0, 1'b1, 4'd0, 3'd0, 1'b1);
        // abort while vector 4 settles; stuck-at-0 leaves one partial mismatch at vector 3
        mode = 1;
        @(negedge CLK);
        bus.START = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        chk("abort_pre_stim", 32'({bus.A1, bus.A2, bus.B1}), 32'd4);
        bus.ABORT = 1'b1;
        @(negedge CLK);
        bus.ABORT = 1'b0;
        chk_idle("abort", 4'd1, 3'd3, 1'b0);
        n_done = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) n_done++;
        end
        chk("abort_quiet", 32'(n_done), 32'd0);
        run("restart", 0, 1'b0, 4'd0, 3'd0, 1'b1);
        // reset during the vector 3 sample cycle
        mode = 1;
        @(negedge CLK);
        bus.START = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        chk("rst_pre_stim", 32'({bus.A1, bus.A2, bus.B1}), 32'd3);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk_idle("midrst", 4'd0, 3'd0, 1'b0);
        n_done = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) n_done++;
        end
        chk("midrst_quiet", 32'(n_done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
